// File: rtl/draw_text_box.sv
// Text-overlay stage: maps a COLS x ROWS grid of 8x16 glyph cells onto a movable
// window and drives font-ROM addresses, delaying timing to match ROM latency.
module draw_text_box #(
    parameter int          XPOS         = 0,
    parameter int          YPOS         = 0,
    parameter int          COLS         = 16,
    parameter int          ROWS         = 16,
    parameter logic [11:0] FONT_COLOUR  = 12'hfff,
    parameter logic [11:0] BG_COLOUR    = 12'h000,
    parameter bit          BG_EN        = 1'b0,
    parameter int          ROM_LATENCY  = 1,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  char_pixel,
    input  logic        pos_load,
    input  logic [11:0] pos_x_in,
    input  logic [11:0] pos_y_in,
    input  logic        blink_en,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [6:0]  char_col,
    output logic [6:0]  char_row,
    output logic [3:0]  char_line
);

    localparam logic [12:0] BOX_W      = 13'(8 * COLS);
    localparam logic [12:0] BOX_H      = 13'(16 * ROWS);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_box;
        logic [2:0]  dx_lo;
    } side_t;

    logic [11:0] ax, ay, px, py;
    logic        pend, vs_prev, phase;
    logic [15:0] frame_cnt;
    logic        frame_start;

    logic [12:0] dx_p0, dy_p0;
    logic        in_box_p0;
    side_t       side_p0;
    side_t       side_p1 [0:ROM_LATENCY];
    side_t       side_p2;
    logic        glyph_p2;

    function automatic logic [11:0] pick_colour(input logic glyph, input logic box,
                                                input logic [11:0] rgb);
        if (glyph)
            return FONT_COLOUR;
        else if (box && BG_EN)
            return BG_COLOUR;
        else
            return rgb;
    endfunction

    assign frame_start = vsync_in & ~vs_prev;

    // A load coinciding with a frame start goes straight to the active origin.
    always_ff @(posedge pclk) begin
        if (rst) begin
            ax        <= 12'(XPOS);
            ay        <= 12'(YPOS);
            px        <= '0;
            py        <= '0;
            pend      <= 1'b0;
            vs_prev   <= 1'b0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            vs_prev <= vsync_in;
            if (pos_load && frame_start) begin
                ax   <= pos_x_in;
                ay   <= pos_y_in;
                pend <= 1'b0;
            end else if (pos_load) begin
                px   <= pos_x_in;
                py   <= pos_y_in;
                pend <= 1'b1;
            end else if (frame_start && pend) begin
                ax   <= px;
                ay   <= py;
                pend <= 1'b0;
            end
            if (frame_start) begin
                if (frame_cnt == BLINK_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

    // Stage p0: box hit test on the raw counters
    always_comb begin
        dx_p0     = {1'b0, hcount_in} - {1'b0, ax};
        dy_p0     = {1'b0, vcount_in} - {1'b0, ay};
        in_box_p0 = (hcount_in >= ax) && (dx_p0 < BOX_W) &&
                    (vcount_in >= ay) && (dy_p0 < BOX_H) &&
                    !hblnk_in && !vblnk_in;
        side_p0   = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in,
                      rgb: rgb_in, in_box: in_box_p0, dx_lo: dx_p0[2:0]};
    end

    // Stage p1: glyph address plus side data delayed across the ROM access
    always_ff @(posedge pclk) begin
        if (rst) begin
            char_col  <= '0;
            char_row  <= '0;
            char_line <= '0;
            for (int k = 0; k <= ROM_LATENCY; k++)
                side_p1[k] <= '0;
        end else begin
            if (in_box_p0) begin
                char_col  <= dx_p0[9:3];
                char_row  <= dy_p0[10:4];
                char_line <= dy_p0[3:0];
            end else begin
                char_col  <= '0;
                char_row  <= '0;
                char_line <= '0;
            end
            side_p1[0] <= side_p0;
            for (int k = 1; k <= ROM_LATENCY; k++)
                side_p1[k] <= side_p1[k-1];
        end
    end

    // Stage p2: colour selection once char_pixel is valid
    always_comb begin
        side_p2  = side_p1[ROM_LATENCY];
        glyph_p2 = side_p2.in_box & char_pixel[3'd7 - side_p2.dx_lo] & ~(blink_en & phase);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= side_p2.hcount;
            vcount_out <= side_p2.vcount;
            hsync_out  <= side_p2.hsync;
            vsync_out  <= side_p2.vsync;
            hblnk_out  <= side_p2.hblnk;
            vblnk_out  <= side_p2.vblnk;
            rgb_out    <= pick_colour(glyph_p2, side_p2.in_box, side_p2.rgb);
        end
    end

endmodule

// File: tb/tb_draw_text_box.sv
// Directed bench: three draw_text_box instances (ROM latency 1, 0, 3) share one
// stimulus stream; each is fed by its own font-ROM model of matching latency.
module tb_draw_text_box;

    localparam logic [11:0] R   = 12'h123;
    localparam logic [11:0] FFF = 12'hfff;
    localparam logic [11:0] G   = 12'h0f0;
    localparam logic [11:0] B   = 12'h00f;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, rgb_in, pos_x_in, pos_y_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in, pos_load, blink_en;

    logic [11:0] hc_a, vc_a, rgb_a, hc_b, vc_b, rgb_b, hc_c, vc_c, rgb_c;
    logic        hs_a, vs_a, hb_a, vb_a, hs_b, vs_b, hb_b, vb_b, hs_c, vs_c, hb_c, vb_c;
    logic [6:0]  col_a, row_a, col_b, row_b, col_c, row_c;
    logic [3:0]  line_a, line_b, line_c;
    logic [7:0]  pix_a, pix_b, pix_c, c_r1, c_r2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    // Odd columns are blank; even columns hold an asymmetric row so bit order shows.
    function automatic logic [7:0] rom_f(input logic [6:0] col);
        return col[0] ? 8'h00 : 8'hC1;
    endfunction

    always_ff @(posedge pclk) pix_a <= rom_f(col_a);
    assign pix_b = rom_f(col_b);
    always_ff @(posedge pclk) begin
        c_r1  <= rom_f(col_c);
        c_r2  <= c_r1;
        pix_c <= c_r2;
    end

    draw_text_box #(.ROM_LATENCY(1), .BLINK_FRAMES(2)) u_a (
        .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixel(pix_a), .pos_load(pos_load), .pos_x_in(pos_x_in),
        .pos_y_in(pos_y_in), .blink_en(blink_en), .hcount_out(hc_a), .vcount_out(vc_a),
        .hsync_out(hs_a), .vsync_out(vs_a), .hblnk_out(hb_a), .vblnk_out(vb_a),
        .rgb_out(rgb_a), .char_col(col_a), .char_row(row_a), .char_line(line_a));

    draw_text_box #(.XPOS(16), .YPOS(32), .COLS(2), .ROWS(1), .FONT_COLOUR(G),
                    .BG_COLOUR(B), .BG_EN(1'b1), .ROM_LATENCY(0), .BLINK_FRAMES(2)) u_b (
        .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixel(pix_b), .pos_load(pos_load), .pos_x_in(pos_x_in),
        .pos_y_in(pos_y_in), .blink_en(blink_en), .hcount_out(hc_b), .vcount_out(vc_b),
        .hsync_out(hs_b), .vsync_out(vs_b), .hblnk_out(hb_b), .vblnk_out(vb_b),
        .rgb_out(rgb_b), .char_col(col_b), .char_row(row_b), .char_line(line_b));

    draw_text_box #(.ROM_LATENCY(3), .BLINK_FRAMES(2)) u_c (
        .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixel(pix_c), .pos_load(pos_load), .pos_x_in(pos_x_in),
        .pos_y_in(pos_y_in), .blink_en(blink_en), .hcount_out(hc_c), .vcount_out(vc_c),
        .hsync_out(hs_c), .vsync_out(vs_c), .hblnk_out(hb_c), .vblnk_out(vb_c),
        .rgb_out(rgb_c), .char_col(col_c), .char_row(row_c), .char_line(line_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_side(input string tag, input logic [11:0] rgb_o, hc_o, vc_o,
                            input logic hs_o, hb_o, vb_o,
                            input logic [11:0] erg, eh, ev);
        chk($sformatf("%s_rgb(%0d,%0d)", tag, eh, ev), rgb_o, erg);
        chk($sformatf("%s_hcount", tag), hc_o, eh);
        chk($sformatf("%s_vcount", tag), vc_o, ev);
        chk($sformatf("%s_hsync", tag), hs_o, 1);
        chk($sformatf("%s_hblnk", tag), hb_o, 0);
        chk($sformatf("%s_vblnk", tag), vb_o, 0);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        hcount_in = 12'h7ff; vcount_in = 12'h7ff;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b1; vblnk_in = 1'b1;
        rgb_in = 12'h000; pos_load = 1'b0;
    endtask

    // One active pixel, then idle; each DUT is checked exactly at its latency.
    task automatic vec(input logic [11:0] h, v, input logic [11:0] ea, eb, ec);
        hcount_in = h; vcount_in = v; hsync_in = 1'b1; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = R; pos_load = 1'b0;
        tick();
        idle();
        tick();
        chk_side("b", rgb_b, hc_b, vc_b, hs_b, hb_b, vb_b, eb, h, v);
        tick();
        chk_side("a", rgb_a, hc_a, vc_a, hs_a, hb_a, vb_a, ea, h, v);
        tick();
        tick();
        chk_side("c", rgb_c, hc_c, vc_c, hs_c, hb_c, vb_c, ec, h, v);
    endtask

    task automatic frame_rise(input logic ld, input logic [11:0] x, y);
        idle();
        vsync_in = 1'b1; pos_load = ld; pos_x_in = x; pos_y_in = y;
        tick();
        idle();
        tick();
        chk("b_vsync", vs_b, 1);
        tick();
        chk("a_vsync", vs_a, 1);
        tick();
        tick();
        chk("c_vsync", vs_c, 1);
    endtask

    task automatic load(input logic [11:0] x, y);
        idle();
        pos_load = 1'b1; pos_x_in = x; pos_y_in = y;
        tick();
        pos_load = 1'b0;
    endtask

    initial begin
        idle();
        blink_en = 1'b0; pos_x_in = '0; pos_y_in = '0;
        rst = 1'b1;
        hcount_in = 12'd37; vcount_in = 12'd50; hsync_in = 1'b1;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = R;
        repeat (6) tick();
        chk("rst_a_rgb", rgb_a, 0);
        chk("rst_a_hcount", hc_a, 0);
        chk("rst_a_hsync", hs_a, 0);
        chk("rst_a_col", col_a, 0);
        chk("rst_b_rgb", rgb_b, 0);
        chk("rst_c_hcount", hc_c, 0);
        chk("rst_c_line", line_c, 0);

        // Address stage
        rst = 1'b0;
        tick();
        chk("a_col", col_a, 4);
        chk("a_row", row_a, 3);
        chk("a_line", line_a, 2);
        chk("c_col", col_c, 4);
        chk("c_row", row_c, 3);
        chk("c_line", line_c, 2);
        chk("b_col_out", col_b, 0);
        chk("b_row_out", row_b, 0);
        chk("b_line_out", line_b, 0);
        hcount_in = 12'd200; vcount_in = 12'd10;
        tick();
        chk("a_col_out", col_a, 0);
        chk("a_row_out", row_a, 0);
        chk("a_line_out", line_a, 0);
        hcount_in = 12'd37; vcount_in = 12'd250;
        tick();
        chk("a_col_edge", col_a, 4);
        chk("a_row_edge", row_a, 15);
        chk("a_line_edge", line_a, 10);
        idle();
        repeat (6) tick();

        // Glyph bits, boxes, clipping, background fill
        vec(0, 0, FFF, R, FFF);
        vec(2, 0, R, R, R);
        vec(7, 3, FFF, R, FFF);
        vec(9, 0, R, R, R);
        vec(17, 33, FFF, G, FFF);
        vec(18, 32, R, B, R);
        vec(23, 32, FFF, G, FFF);
        vec(24, 47, R, B, R);
        vec(31, 47, R, B, R);
        vec(32, 32, FFF, R, FFF);
        vec(16, 48, FFF, R, FFF);
        vec(15, 40, R, R, R);
        vec(112, 255, FFF, R, FFF);
        vec(119, 0, FFF, R, FFF);
        vec(128, 0, R, R, R);
        vec(0, 256, R, R, R);

        // Position change takes effect only at the next frame start
        load(100, 200);
        vec(0, 0, FFF, R, FFF);
        vec(100, 200, R, R, R);
        frame_rise(1'b0, 0, 0);
        vec(100, 200, FFF, G, FFF);
        vec(0, 0, R, R, R);
        vec(99, 200, R, R, R);
        vec(100, 199, R, R, R);

        // Only the last of several loads applies
        load(300, 300);
        load(40, 8);
        frame_rise(1'b0, 0, 0);
        vec(40, 8, FFF, G, FFF);
        vec(300, 300, R, R, R);

        // Load on the frame-start cycle wins and drops the older pending value
        load(200, 100);
        frame_rise(1'b1, 64, 64);
        vec(64, 64, FFF, G, FFF);
        frame_rise(1'b0, 0, 0);
        vec(64, 64, FFF, G, FFF);

        // Mid-line reset clears the pipeline and the pending position
        load(100, 200);
        hcount_in = 12'd37; vcount_in = 12'd50; hsync_in = 1'b1;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = R;
        tick();
        idle();
        rst = 1'b1;
        tick();
        chk("mrst_a_rgb", rgb_a, 0);
        chk("mrst_a_hcount", hc_a, 0);
        chk("mrst_a_vblnk", vb_a, 0);
        chk("mrst_a_col", col_a, 0);
        chk("mrst_b_hblnk", hb_b, 0);
        chk("mrst_c_hcount", hc_c, 0);
        rst = 1'b0;
        frame_rise(1'b0, 0, 0);
        vec(0, 0, FFF, R, FFF);
        vec(16, 32, FFF, G, FFF);

        // Blink with a two-frame half period; background stays painted
        blink_en = 1'b1;
        vec(16, 32, FFF, G, FFF);
        frame_rise(1'b0, 0, 0);
        vec(16, 32, R, B, R);
        vec(0, 0, R, R, R);
        frame_rise(1'b0, 0, 0);
        vec(16, 32, R, B, R);
        frame_rise(1'b0, 0, 0);
        vec(16, 32, FFF, G, FFF);
        frame_rise(1'b0, 0, 0);
        frame_rise(1'b0, 0, 0);
        vec(16, 32, R, B, R);
        blink_en = 1'b0;
        vec(16, 32, FFF, G, FFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/draw_text_box.md
# draw_text_box

Parametrised text-overlay stage for the VGA pipeline. It sits between the background/rect stages and the output register. It maps a COLS×ROWS grid of 8×16 glyph cells onto a movable screen window and drives glyph addresses to an external font ROM of configurable latency. It also delays all timing signals to match that latency, and supports a frame-synchronous position update and an optional blink.

## Interface
Parameters:
- XPOS, 0: reset x of box left edge (pixels).
- YPOS, 0: reset y of box top edge (pixels).
- COLS, 16: character columns, 1..128.
- ROWS, 16: character rows, 1..128.
- FONT_COLOUR, 12'hfff: glyph pixel colour.
- BG_COLOUR, 12'h000: box background colour.
- BG_EN, 0: 1 = paint BG_COLOUR on non-glyph pixels inside the box; 0 = pass rgb_in.
- ROM_LATENCY, 1: cycles from char address to valid char_pixel, 0..4.
- BLINK_FRAMES, 30: frames per blink half-period, ≥1.

Ports:
- pclk, input, 1: pixel clock. All logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- hcount_in, vcount_in, input, 12 each: pixel counters.
- hsync_in, vsync_in, hblnk_in, vblnk_in, input, 1 each: timing.
- rgb_in, input, 12: upstream colour.
- char_pixel, input, 8: font ROM row. Bit 7 is the leftmost pixel.
- pos_load, input, 1: one-cycle strobe that captures pos_x_in/pos_y_in.
- pos_x_in, pos_y_in, input, 12 each: requested box origin.
- blink_en, input, 1: enable glyph blinking.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, output: timing/colour delayed by L.
- char_col, output, 7: column index of the current cell.
- char_row, output, 7: row index of the current cell.
- char_line, output, 4: glyph line within the cell (0..15).

## Operation
- Active origin registers ax/ay. Pending registers px/py with pend flag.
- pos_load=1: px/py ← pos_x_in/pos_y_in, pend ← 1.
- Frame start is a vsync_in rising edge (vsync_in=1, registered previous value=0). On frame start with pend=1: ax/ay ← px/py, pend ← 0.
- pos_load on the same cycle as a frame start: ax/ay ← pos_x_in/pos_y_in directly and pend ← 0. The load wins.
- Box arithmetic is 13-bit unsigned:
  - dx = hcount_in − ax, dy = vcount_in − ay.
  - in_box = (hcount_in ≥ ax) & (dx < 8·COLS) & (vcount_in ≥ ay) & (dy < 16·ROWS) & !hblnk_in & !vblnk_in.
  - A box extending past 4095 is clipped naturally. It never wraps to the left or top.
- Address stage (registered):
  - in_box: char_col ← dx[9:3], char_row ← dy[10:4], char_line ← dy[3:0].
  - Outside the box: all three ← 0.
- Side data dx[2:0], in_box and the timing/rgb_in bundle are delayed alongside the ROM access.
- Colour selection in the output stage:
  - glyph = in_box_d & char_pixel[7 − dx_d[2:0]] & !(blink_en & phase).
  - rgb_out ← glyph ? FONT_COLOUR : (in_box_d & BG_EN) ? BG_COLOUR : rgb_d.
- Blink:
  - frame_cnt increments on each frame start.
  - When frame_cnt = BLINK_FRAMES−1 it wraps to 0 and phase toggles.
  - The counter runs regardless of blink_en.
  - Background painting is unaffected by phase.

## Timing
- Latency L = ROM_LATENCY + 2 cycles, input to every *_out port. The pipeline carries one pixel per cycle with no stalls.
- char_col/row/line are registered 1 cycle after the inputs.
- char_pixel is sampled ROM_LATENCY cycles after the address is presented.
- With ROM_LATENCY = 0, the ROM is combinational and char_pixel is sampled in the same cycle as the address.
- Reset values:
  - All *_out ports, char_col/row/line and all delay-line stages: 0.
  - ax/ay: XPOS/YPOS.
  - px/py/pend/frame_cnt/phase: 0.
- rst asserted mid-frame clears the pipeline in 1 cycle. The first valid output appears L cycles after rst deasserts, and a previously pending position is discarded.
- A pos_load between frame starts never changes the box within the current frame.
- Multiple pos_loads before a frame start: only the last one is applied.

## Test plan
- ROM_LATENCY=1, XPOS=YPOS=0, a ROM model returning 8'h80 for every address; a 640×480 frame → rgb_out=12'hfff exactly at hcount_out ∈ {0,8,…,120} for vcount_out 0..255; all other pixels equal to rgb_in delayed 3 cycles; the sync outputs equal the inputs delayed 3 cycles.
- hcount_in=37, vcount_in=50 with the box at (0,0) → one cycle later char_col=4, char_row=3, char_line=2. A pixel outside the box → char_col/row/line = 0.
- pos_load with (100,200) mid-frame → the box is unchanged until the next vsync_in rise, then the top-left glyph pixel appears at hcount_out=100, vcount_out=200.
- pos_load on the same cycle as a vsync_in rise → the new origin is used in that frame; pend is 0 afterwards.
- BLINK_FRAMES=2, blink_en=1, BG_EN=1 → glyphs visible for frames 0–1, hidden for 2–3 (box filled with BG_COLOUR), visible again for 4–5.
- ROM_LATENCY ∈ {0,3} → L = 2 and 5 respectively; glyph bit alignment is correct, with bit 7 at dx%8=0.
- rst pulsed mid-line → all outputs 0 on the next cycle; ax/ay = XPOS/YPOS.
